sin_debounce: RTL

Input conditioner that sits directly upstream of the 16-bit switch/key PIO (`in_port`) in the Qsys LED/switch subsystem. It synchronises asynchronous board inputs into `clk`, debounces each bit with a shared sample tick and a per-bit stability counter, and drives the clean level onto the PIO's `in_port`. It also keeps a sticky per-bit edge-capture register and a one-cycle change strobe for firmware polling or interrupt logic.

---
 rtl/sin_debounce_if.sv | 61 ++++++
 rtl/sin_debounce.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sin_debounce_if.sv
// ---------------------------------------------------------------------------
// sin_debounce_if
//   Bundle of the signals between the switch/key input conditioner and its
//   environment (board pins on one side, the PIO in_port on the other).
//
//   Signals:
//     raw_in   : asynchronous board switches/keys (environment -> conditioner)
//     clr_edge : write-1-to-clear strobe for edge_cap bits (environment -> conditioner)
//     out_port : debounced level, feeds the PIO in_port (conditioner -> environment)
//     changed  : one-cycle pulse after any out_port bit changes
//     edge_cap : sticky per-bit change flags, present only when
//                SIN_EDGE_CAPTURE_EN is defined
//
//   Modports:
//     master : environment side (drives raw_in/clr_edge, observes outputs)
//     slave  : the conditioner itself
//
//   Build macro: SIN_EDGE_CAPTURE_EN (adds edge_cap and uses clr_edge).
// ---------------------------------------------------------------------------
interface sin_debounce_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clr_edge;
   logic [WIDTH-1:0] out_port;
   logic             changed;
`ifdef SIN_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] edge_cap;

   modport master (
      output raw_in,
      output clr_edge,
      input  out_port,
      input  changed,
      input  edge_cap
   );

   modport slave (
      input  raw_in,
      input  clr_edge,
      output out_port,
      output changed,
      output edge_cap
   );
`else
   // Without edge capture the conditioner has no use for clr_edge, so the
   // slave view leaves it unconnected.
   modport master (
      output raw_in,
      output clr_edge,
      input  out_port,
      input  changed
   );

   modport slave (
      input  raw_in,
      output out_port,
      output changed
   );
`endif
endinterface

// File: rtl/sin_debounce.sv
// ---------------------------------------------------------------------------
// sin_debounce
//   Input conditioner for the 16-bit switch/key PIO. Board inputs are
//   synchronised into clk, each bit is debounced against a shared free-running
//   sample tick with a per-bit stability counter, and the clean level is
//   driven to out_port. A one-cycle 'changed' strobe follows every update,
//   and an optional sticky per-bit edge-capture register records updates for
//   firmware polling.
//
//   Parameters:
//     WIDTH      : number of input bits
//     TICK_DIV   : clk cycles per sample tick (>= 2)
//     STABLE_CNT : consecutive differing ticks needed to accept a level (>= 1)
//
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-high; clears every register
//     bus    : sin_debounce_if.slave (raw_in, clr_edge, out_port, changed,
//              edge_cap)
//
//   Build macro: SIN_EDGE_CAPTURE_EN builds edge_cap and its clr_edge logic.
//   Without it out_port/changed behave identically and clr_edge is ignored.
// ---------------------------------------------------------------------------
module sin_debounce #(
   parameter int WIDTH      = 16,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input logic          clk,
   input logic          reset,
   sin_debounce_if.slave bus
);

   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] flip_d;
   logic             upd_q;
   logic             changed_q;

   // Sample tick: one cycle in TICK_DIV, phase fixed by time since reset.
   assign tick  = (pre_q == PRE_MAX);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   // Per-bit stability counters. Any tick that sees the current level
   // restarts the count, so only an uninterrupted run of STABLE_CNT
   // differing ticks flips the output bit.
   always_comb begin
      flip_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (tick) begin
            if (sync2_q[i] == out_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               cnt_d[i]  = '0;
               flip_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      out_d = out_q ^ flip_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         pre_q     <= '0;
         out_q     <= '0;
         upd_q     <= 1'b0;
         changed_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= bus.raw_in;
         sync2_q   <= sync1_q;
         pre_q     <= pre_d;
         out_q     <= out_d;
         // upd_q marks the update edge; changed follows one cycle later so
         // the strobe appears in the cycle after out_port moves.
         upd_q     <= |flip_d;
         changed_q <= upd_q;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.out_port = out_q;
   assign bus.changed  = changed_q;

`ifdef SIN_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] edge_d;

   // Set takes priority over a same-cycle clear so no update is lost.
   assign edge_d = (edge_q & ~bus.clr_edge) | flip_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_d;
      end
   end

   assign bus.edge_cap = edge_q;
`endif

endmodule
